// File: rtl/aes_decrypt_iter_if.sv
// Handshake bundle between a ciphertext source / plaintext sink and aes_decrypt_iter.
// The slave modport is the decryptor side; master is the source/sink side.
interface aes_decrypt_iter_if #(
   parameter int unsigned KEY_LEN = 128
);
   logic               key_load;
   logic [KEY_LEN-1:0] key;
   logic               key_ready;
   logic               in_valid;
   logic               in_ready;
   logic [127:0]       in;
   logic               out_valid;
   logic               out_ready;
   logic [127:0]       out;
   logic               busy;

   modport master (
      output key_load, key, in_valid, in, out_ready,
      input  key_ready, in_ready, out_valid, out, busy
   );

   modport slave (
      input  key_load, key, in_valid, in, out_ready,
      output key_ready, in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES decryptor: on-chip key expansion (one word per clock) followed by one
// inverse round per clock on a single block. Optional status counter enabled by the
// AES_DEC_STATUS_EN macro adds the blk_cnt output (completed output handshakes).
module aes_decrypt_iter #(
   parameter int unsigned KEY_LEN = 128,
   parameter int unsigned NR      = 10,
   parameter int unsigned NK      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   aes_decrypt_iter_if.slave dec_if
`ifdef AES_DEC_STATUS_EN
   ,
   output logic [15:0]       blk_cnt
`endif
);
   localparam int unsigned NW = 4 * (NR + 1);

   typedef enum logic [1:0] {StIdle, StKexp, StRound} state_e;

   state_e        state_q, state_d;
   logic [31:0]   w_q [NW];
   logic [31:0]   w_d [NW];
   logic [5:0]    widx_q, widx_d;
   logic [2:0]    kmod_q, kmod_d;
   logic [7:0]    rcon_q, rcon_d;
   logic [127:0]  blk_q, blk_d;
   logic [3:0]    rcnt_q, rcnt_d;
   logic          key_ready_q, key_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [127:0]  out_q, out_d;

   logic          in_rdy, in_fire, out_fire, load_fire;
   logic [5:0]    rk_base;
   logic [127:0]  rk_sel, round_res;
   logic [31:0]   kexp_tmp, kexp_word;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] y;
      y = a;
      for (int i = 0; i < 6; i++) y = gf_mul(gf_mul(y, y), a);
      return gf_mul(y, y);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0]  a [4];
      logic [31:0] r;
      for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
         r[31-8*i -: 8] = gf_mul(a[i], 8'h0e) ^ gf_mul(a[(i+1)%4], 8'h0b) ^
                          gf_mul(a[(i+2)%4], 8'h0d) ^ gf_mul(a[(i+3)%4], 8'h09);
      end
      return r;
   endfunction

   // Byte n sits at row n%4, column n/4; InvShiftRows rotates row r right by r
   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic mix);
      logic [127:0] r;
      int           src;
      for (int n = 0; n < 16; n++) begin
         src = 4 * (((n / 4) - (n % 4) + 4) % 4) + (n % 4);
         r[127-8*n -: 8] = inv_sbox(s[127-8*src -: 8]);
      end
      r = r ^ rk;
      if (mix) begin
         for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_col(r[127-32*c -: 32]);
      end
      return r;
   endfunction

   // Handshake qualifiers; key_load in IDLE takes priority over an offered block
   assign in_rdy    = (state_q == StIdle) & key_ready_q & ~dec_if.key_load &
                      (~out_valid_q | dec_if.out_ready);
   assign in_fire   = dec_if.in_valid & in_rdy;
   assign out_fire  = out_valid_q & dec_if.out_ready;
   assign load_fire = (state_q == StIdle) & dec_if.key_load;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (dec_if.key_load) state_d = StKexp;
            else if (in_fire)    state_d = StRound;
         end
         StKexp:  if (widx_q == 6'(NW - 1)) state_d = StIdle;
         StRound: if (rcnt_q == 4'd0)       state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath: round-key select, schedule word generation and register next values
   always_comb begin
      rk_base   = (state_q == StRound) ? {rcnt_q, 2'b00} : 6'(4 * NR);
      rk_sel    = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
      round_res = inv_round(blk_q, rk_sel, rcnt_q != 4'd0);

      kexp_tmp = w_q[widx_q - 6'd1];
      if (kmod_q == 3'd0) begin
         kexp_tmp = sub_word({kexp_tmp[23:0], kexp_tmp[31:24]}) ^ {rcon_q, 24'h0};
      end else if (NK == 8 && kmod_q == 3'd4) begin
         kexp_tmp = sub_word(kexp_tmp);
      end
      kexp_word = w_q[widx_q - 6'(NK)] ^ kexp_tmp;

      w_d         = w_q;
      widx_d      = widx_q;
      kmod_d      = kmod_q;
      rcon_d      = rcon_q;
      blk_d       = blk_q;
      rcnt_d      = rcnt_q;
      key_ready_d = key_ready_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;

      if (out_fire) out_valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (load_fire) begin
               for (int k = 0; k < NK; k++) w_d[k] = dec_if.key[KEY_LEN-1-32*k -: 32];
               widx_d      = 6'(NK);
               kmod_d      = 3'd0;
               rcon_d      = 8'h01;
               key_ready_d = 1'b0;
            end else if (in_fire) begin
               blk_d  = dec_if.in ^ rk_sel;
               rcnt_d = 4'(NR - 1);
            end
         end
         StKexp: begin
            w_d[widx_q] = kexp_word;
            widx_d      = widx_q + 6'd1;
            kmod_d      = (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
            if (kmod_q == 3'd0)          rcon_d      = xtime(rcon_q);
            if (widx_q == 6'(NW - 1))    key_ready_d = 1'b1;
         end
         StRound: begin
            blk_d  = round_res;
            rcnt_d = rcnt_q - 4'd1;
            if (rcnt_q == 4'd0) begin
               out_d       = round_res;
               out_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NW; k++) w_q[k] <= '0;
         widx_q      <= '0;
         kmod_q      <= '0;
         rcon_q      <= '0;
         blk_q       <= '0;
         rcnt_q      <= '0;
         key_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         w_q         <= w_d;
         widx_q      <= widx_d;
         kmod_q      <= kmod_d;
         rcon_q      <= rcon_d;
         blk_q       <= blk_d;
         rcnt_q      <= rcnt_d;
         key_ready_q <= key_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

`ifdef AES_DEC_STATUS_EN
   logic [15:0] blk_cnt_q, blk_cnt_d;

   // Completed-output counter; an accepted key_load clears it
   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if (out_fire)  blk_cnt_d = blk_cnt_q + 16'd1;
      if (load_fire) blk_cnt_d = 16'd0;
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blk_cnt_q <= '0;
      else        blk_cnt_q <= blk_cnt_d;
   end

   assign blk_cnt = blk_cnt_q;
`endif

   // FSM / port outputs
   always_comb begin
      dec_if.key_ready = key_ready_q;
      dec_if.in_ready  = in_rdy;
      dec_if.out_valid = out_valid_q;
      dec_if.out       = out_q;
      dec_if.busy      = (state_q != StIdle);
   end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 vectors for all three key sizes plus
// random blocks checked against a forward-cipher reference model (decrypt(encrypt(p)) == p).
module tb_aes_decrypt_iter;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   logic [7:0]   sbox [256];
   logic [7:0]   rcon_tab [10];
   logic [127:0] cur_key;

   aes_decrypt_iter_if #(.KEY_LEN(128)) if128 ();
   aes_decrypt_iter_if #(.KEY_LEN(192)) if192 ();
   aes_decrypt_iter_if #(.KEY_LEN(256)) if256 ();

`ifdef AES_DEC_STATUS_EN
   logic [15:0] blk_cnt128, blk_cnt192, blk_cnt256;
`endif

   aes_decrypt_iter #(.KEY_LEN(128), .NR(10), .NK(4)) dut128 (
      .clk    (clk),
      .rst_n  (rst_n),
      .dec_if (if128)
`ifdef AES_DEC_STATUS_EN
      ,
      .blk_cnt(blk_cnt128)
`endif
   );

   aes_decrypt_iter #(.KEY_LEN(192), .NR(12), .NK(6)) dut192 (
      .clk    (clk),
      .rst_n  (rst_n),
      .dec_if (if192)
`ifdef AES_DEC_STATUS_EN
      ,
      .blk_cnt(blk_cnt192)
`endif
   );

   aes_decrypt_iter #(.KEY_LEN(256), .NR(14), .NK(8)) dut256 (
      .clk    (clk),
      .rst_n  (rst_n),
      .dec_if (if256)
`ifdef AES_DEC_STATUS_EN
      ,
      .blk_cnt(blk_cnt256)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   // ---------------- reference model (forward cipher) ----------------
   // S-box built by walking GF(2^8) with generator 3 and its inverse
   task automatic init_tables();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
      rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_w(input logic [31:0] x);
      return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
   endfunction

   // key is left-aligned in 256 bits; nk = 4, 6 or 8
   function automatic logic [127:0] ref_encrypt(input logic [255:0] key, input int nk,
                                                input logic [127:0] pt);
      logic [31:0]  w [60];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [127:0] r;
      int           nr;
      nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
         else if (nk > 6 && i % nk == 4) tmp = sub_w(tmp);
         w[i] = w[i-nk] ^ tmp;
      end
      for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int n = 0; n < 16; n++) t[n] = sbox[s[4*(((n/4) + (n%4)) % 4) + n%4]];
         for (int c = 0; c < 4; c++) begin
            for (int q = 0; q < 4; q++) begin
               if (rnd < nr)
                  s[4*c+q] = xt(t[4*c+q]) ^ xt(t[4*c+(q+1)%4]) ^ t[4*c+(q+1)%4] ^
                             t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
               else
                  s[4*c+q] = t[4*c+q];
            end
         end
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
      end
      for (int n = 0; n < 16; n++) r[127-8*n -: 8] = s[n];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- drivers for the AES-128 instance ----------------
   task automatic load_key128(input logic [127:0] k, output int cyc);
      @(negedge clk);
      if128.key      = k;
      if128.key_load = 1'b1;
      @(negedge clk);
      if128.key_load = 1'b0;
      cyc = 0;
      while (!if128.key_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic send_block128(input logic [127:0] ct, input int hold,
                                output logic [127:0] pt, output int lat);
      int n;
      @(negedge clk);
      if128.in       = ct;
      if128.in_valid = 1'b1;
      n = 0;
      #1;
      while (!if128.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if128.in_valid = 1'b0;
      lat = 0;
      while (!if128.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      repeat (hold) @(negedge clk);
      pt              = if128.out;
      if128.out_ready = 1'b1;
      @(negedge clk);
      if128.out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_cmp++;
      if ({if128.key_ready, if128.in_ready, if128.out_valid, if128.busy, if128.out} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got kr=%b ir=%b ov=%b busy=%b out=%h want all 0",
                  if128.key_ready, if128.in_ready, if128.out_valid, if128.busy, if128.out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      if128.in       = rand128();
      if128.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({if128.in_ready, if128.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL no_key_ignore: got in_ready=%b busy=%b want 0 0",
                     if128.in_ready, if128.busy);
         end
      end
      if128.in_valid = 1'b0;
   endtask

   task automatic test_aes128_vector();
      logic [127:0] got;
      int           cyc, lat;
      cur_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      load_key128(cur_key, cyc);
      n_cmp++;
      if (cyc !== 40) begin
         n_err++;
         $display("FAIL kexp128_cycles: got %0d want 40", cyc);
      end
      send_block128(128'h3925841d02dc09fbdc118597196a0b32, 0, got, lat);
      n_cmp++;
      if (got !== 128'h3243f6a8885a308d313198a2e0370734) begin
         n_err++;
         $display("FAIL vec128_pt: got %h want 3243f6a8885a308d313198a2e0370734", got);
      end
      n_cmp++;
      if (lat !== 10) begin
         n_err++;
         $display("FAIL vec128_latency: got %0d want 10", lat);
      end
   endtask

   task automatic test_aes192();
      logic [191:0] k;
      logic [127:0] pt, ct, got;
      int           cyc, lat;
      k = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
      @(negedge clk);
      if192.key      = k;
      if192.key_load = 1'b1;
      @(negedge clk);
      if192.key_load = 1'b0;
      cyc = 0;
      while (!if192.key_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (cyc !== 46) begin
         n_err++;
         $display("FAIL kexp192_cycles: got %0d want 46", cyc);
      end
      for (int b = 0; b < 3; b++) begin
         if (b == 0) begin
            pt = 128'h00112233445566778899aabbccddeeff;
            ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
         end else begin
            pt = rand128();
            ct = ref_encrypt({k, 64'h0}, 6, pt);
         end
         if192.in       = ct;
         if192.in_valid = 1'b1;
         @(negedge clk);
         if192.in_valid = 1'b0;
         lat = 0;
         while (!if192.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
         end
         got             = if192.out;
         if192.out_ready = 1'b1;
         @(negedge clk);
         if192.out_ready = 1'b0;
         n_cmp++;
         if (got !== pt || lat !== 12) begin
            n_err++;
            $display("FAIL aes192_blk%0d: got %h lat %0d want %h lat 12", b, got, lat, pt);
         end
      end
   endtask

   task automatic test_aes256();
      logic [255:0] k;
      logic [127:0] pt, ct, got;
      int           cyc, lat;
      k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      @(negedge clk);
      if256.key      = k;
      if256.key_load = 1'b1;
      @(negedge clk);
      if256.key_load = 1'b0;
      cyc = 0;
      while (!if256.key_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (cyc !== 52) begin
         n_err++;
         $display("FAIL kexp256_cycles: got %0d want 52", cyc);
      end
      for (int b = 0; b < 3; b++) begin
         if (b == 0) begin
            pt = 128'h00112233445566778899aabbccddeeff;
            ct = 128'h8ea2b7ca516745bfeafc49904b496089;
         end else begin
            pt = rand128();
            ct = ref_encrypt(k, 8, pt);
         end
         if256.in       = ct;
         if256.in_valid = 1'b1;
         @(negedge clk);
         if256.in_valid = 1'b0;
         lat = 0;
         while (!if256.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
         end
         got             = if256.out;
         if256.out_ready = 1'b1;
         @(negedge clk);
         if256.out_ready = 1'b0;
         n_cmp++;
         if (got !== pt || lat !== 14) begin
            n_err++;
            $display("FAIL aes256_blk%0d: got %h lat %0d want %h lat 14", b, got, lat, pt);
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] pt, got;
      int           cyc, lat;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            cur_key = rand128();
            load_key128(cur_key, cyc);
            n_cmp++;
            if (cyc !== 40) begin
               n_err++;
               $display("FAIL rand_kexp%0d: got %0d want 40", i, cyc);
            end
         end
         pt = rand128();
         send_block128(ref_encrypt({cur_key, 128'h0}, 4, pt), $urandom_range(0, 3), got, lat);
         n_cmp++;
         if (got !== pt || lat !== 10) begin
            n_err++;
            $display("FAIL rand_blk%0d: got %h lat %0d want %h lat 10", i, got, lat, pt);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] pa, pb;
      int           lat;
      pa = rand128();
      pb = rand128();
      @(negedge clk);
      if128.in       = ref_encrypt({cur_key, 128'h0}, 4, pa);
      if128.in_valid = 1'b1;
      @(negedge clk);
      if128.in_valid = 1'b0;
      lat = 0;
      while (!if128.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if128.in       = ref_encrypt({cur_key, 128'h0}, 4, pb);
      if128.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (if128.out !== pa || if128.out_valid !== 1'b1 || if128.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_hold%0d: got out=%h ov=%b ir=%b want %h 1 0",
                     i, if128.out, if128.out_valid, if128.in_ready, pa);
         end
         @(negedge clk);
      end
      if128.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (if128.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_in_ready: got %b want 1", if128.in_ready);
      end
      @(negedge clk);
      if128.in_valid  = 1'b0;
      if128.out_ready = 1'b0;
      n_cmp++;
      if ({if128.out_valid, if128.busy} !== 2'b01) begin
         n_err++;
         $display("FAIL b2b_same_edge: got ov=%b busy=%b want 0 1", if128.out_valid, if128.busy);
      end
      lat = 0;
      while (!if128.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if (if128.out !== pb || lat !== 10) begin
         n_err++;
         $display("FAIL b2b_second: got %h lat %0d want %h lat 10", if128.out, lat, pb);
      end
      if128.out_ready = 1'b1;
      @(negedge clk);
      if128.out_ready = 1'b0;
   endtask

   task automatic test_key_load_ignored();
      logic [127:0] pt, ct, got, nkey;
      int           lat, cyc;
      pt = rand128();
      ct = ref_encrypt({cur_key, 128'h0}, 4, pt);
      @(negedge clk);
      if128.in       = ct;
      if128.in_valid = 1'b1;
      @(negedge clk);
      if128.in_valid = 1'b0;
      lat = 0;
      repeat (3) begin
         @(negedge clk);
         lat++;
      end
      if128.key      = rand128();
      if128.key_load = 1'b1;
      @(negedge clk);
      lat++;
      if128.key_load = 1'b0;
      n_cmp++;
      if ({if128.busy, if128.key_ready} !== 2'b11) begin
         n_err++;
         $display("FAIL round_keyload_state: got busy=%b kr=%b want 1 1",
                  if128.busy, if128.key_ready);
      end
      while (!if128.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      got             = if128.out;
      if128.out_ready = 1'b1;
      @(negedge clk);
      if128.out_ready = 1'b0;
      n_cmp++;
      if (got !== pt || lat !== 10) begin
         n_err++;
         $display("FAIL round_keyload_pt: got %h lat %0d want %h lat 10", got, lat, pt);
      end
      // key_load and in_valid together: the key wins
      nkey           = rand128();
      if128.key      = nkey;
      if128.key_load = 1'b1;
      if128.in       = ct;
      if128.in_valid = 1'b1;
      #1;
      n_cmp++;
      if (if128.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL keyload_beats_in: got in_ready=%b want 0", if128.in_ready);
      end
      @(negedge clk);
      if128.key_load = 1'b0;
      if128.in_valid = 1'b0;
      n_cmp++;
      if ({if128.busy, if128.key_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL keyload_restart: got busy=%b kr=%b want 1 0", if128.busy, if128.key_ready);
      end
      cyc = 0;
      while (!if128.key_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      cur_key = nkey;
      pt      = rand128();
      send_block128(ref_encrypt({cur_key, 128'h0}, 4, pt), 0, got, lat);
      n_cmp++;
      if (got !== pt || cyc !== 40) begin
         n_err++;
         $display("FAIL new_key_use: got %h kexp %0d want %h kexp 40", got, cyc, pt);
      end
   endtask

   task automatic test_reset_mid_round();
      logic [127:0] pt, got;
      int           cyc, lat;
      @(negedge clk);
      if128.in       = ref_encrypt({cur_key, 128'h0}, 4, rand128());
      if128.in_valid = 1'b1;
      @(negedge clk);
      if128.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({if128.key_ready, if128.in_ready, if128.out_valid, if128.busy, if128.out} !== '0) begin
         n_err++;
         $display("FAIL mid_round_reset: got kr=%b ir=%b ov=%b busy=%b out=%h want all 0",
                  if128.key_ready, if128.in_ready, if128.out_valid, if128.busy, if128.out);
      end
      @(negedge clk);
      rst_n          = 1'b1;
      if128.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({if128.in_ready, if128.busy, if128.out_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL post_reset_ignore%0d: got ir=%b busy=%b ov=%b want 0 0 0",
                     i, if128.in_ready, if128.busy, if128.out_valid);
         end
      end
      if128.in_valid = 1'b0;
      load_key128(cur_key, cyc);
      pt = rand128();
      send_block128(ref_encrypt({cur_key, 128'h0}, 4, pt), 1, got, lat);
      n_cmp++;
      if (got !== pt || cyc !== 40 || lat !== 10) begin
         n_err++;
         $display("FAIL post_reset_blk: got %h kexp %0d lat %0d want %h 40 10", got, cyc, lat, pt);
      end
   endtask

`ifdef AES_DEC_STATUS_EN
   task automatic test_status();
      logic [127:0] pt, got;
      int           cyc, lat;
      load_key128(cur_key, cyc);
      n_cmp++;
      if (blk_cnt128 !== 16'd0) begin
         n_err++;
         $display("FAIL blk_cnt_after_load: got %0d want 0", blk_cnt128);
      end
      for (int i = 0; i < 3; i++) begin
         pt = rand128();
         send_block128(ref_encrypt({cur_key, 128'h0}, 4, pt), 0, got, lat);
      end
      n_cmp++;
      if (blk_cnt128 !== 16'd3) begin
         n_err++;
         $display("FAIL blk_cnt_three: got %0d want 3", blk_cnt128);
      end
      load_key128(cur_key, cyc);
      n_cmp++;
      if (blk_cnt128 !== 16'd0) begin
         n_err++;
         $display("FAIL blk_cnt_cleared: got %0d want 0", blk_cnt128);
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      init_tables();
      if128.key_load = 1'b0; if128.key = '0; if128.in_valid = 1'b0; if128.in = '0;
      if128.out_ready = 1'b0;
      if192.key_load = 1'b0; if192.key = '0; if192.in_valid = 1'b0; if192.in = '0;
      if192.out_ready = 1'b0;
      if256.key_load = 1'b0; if256.key = '0; if256.in_valid = 1'b0; if256.in = '0;
      if256.out_ready = 1'b0;
      test_reset();
      test_aes128_vector();
      test_aes192();
      test_aes256();
      test_random();
      test_back_to_back();
      test_key_load_ignored();
      test_reset_mid_round();
`ifdef AES_DEC_STATUS_EN
      test_status();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
